// File: rtl/seq_table_counter.sv
// Table-driven sequence counter: steps an index through a programmable flop table, with wrap/saturate ends and a tc pulse.
// Optional down stepping (dir port) is compiled in with `define SEQ_CNT_DOWN_EN.
module seq_table_counter #(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 7,
  parameter int IDXW     = $clog2(DEPTH),
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
`ifdef SEQ_CNT_DOWN_EN
  input  logic             dir,
`endif
  input  logic             load,
  input  logic [IDXW-1:0]  load_idx,
  input  logic             wr_en,
  input  logic [IDXW-1:0]  wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] q,
  output logic [IDXW-1:0]  idx,
  output logic             tc
);

  localparam int DFLT [16] = '{1, 2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47};
  localparam logic [IDXW-1:0] LAST = IDXW'(DEPTH - 1);

  if (DEPTH < 2 || DEPTH > 16) begin : g_bad_depth
    $error("seq_table_counter: DEPTH must be in 2..16");
  end

  logic [WIDTH-1:0] tbl [DEPTH];
  logic [IDXW-1:0]  nxt_idx;
  logic             nxt_tc;
  logic [WIDTH-1:0] nxt_q;

  // One flop entry per table slot; out-of-range write addresses match no slot.
  for (genvar i = 0; i < DEPTH; i++) begin : g_tbl
    always_ff @(posedge clk) begin
      if (clear)                              tbl[i] <= WIDTH'(DFLT[i]);
      else if (wr_en && wr_addr == IDXW'(i))  tbl[i] <= wr_data;
    end
  end

  always_comb begin
    nxt_idx = idx;
    nxt_tc  = 1'b0;
    if (load) begin
      nxt_idx = (load_idx > LAST) ? LAST : load_idx;
    end else if (en) begin
`ifdef SEQ_CNT_DOWN_EN
      if (!dir) begin
        if (idx != '0) nxt_idx = idx - 1'b1;
        else begin
          nxt_tc = 1'b1;
          if (SATURATE == 0) nxt_idx = LAST;
        end
      end else
`endif
      begin
        if (idx != LAST) nxt_idx = idx + 1'b1;
        else begin
          nxt_tc = 1'b1;
          if (SATURATE == 0) nxt_idx = '0;
        end
      end
    end
  end

  // Forward a same-cycle write so q never shows a stale entry.
  assign nxt_q = (wr_en && wr_addr == nxt_idx) ? wr_data : tbl[nxt_idx];

  always_ff @(posedge clk) begin
    if (clear) begin
      idx <= '0;
      q   <= WIDTH'(DFLT[0]);
      tc  <= 1'b0;
    end else begin
      idx <= nxt_idx;
      q   <= nxt_q;
      tc  <= nxt_tc;
    end
  end

endmodule

// File: tb/tb_seq_table_counter.sv
// Directed bench for seq_table_counter: default wrap instance, saturate instance and a DEPTH=16 instance.
module tb_seq_table_counter;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Instance A: defaults (DEPTH=7, WIDTH=4, wrap)
  logic a_clr, a_en, a_dir, a_ld, a_we, a_tc;
  logic [2:0] a_li, a_wa, a_idx;
  logic [3:0] a_wd, a_q;
  seq_table_counter u_a (
    .clk(clk), .clear(a_clr), .en(a_en),
`ifdef SEQ_CNT_DOWN_EN
    .dir(a_dir),
`endif
    .load(a_ld), .load_idx(a_li), .wr_en(a_we), .wr_addr(a_wa), .wr_data(a_wd),
    .q(a_q), .idx(a_idx), .tc(a_tc));

  // Instance B: saturate
  logic b_clr, b_en, b_dir, b_ld, b_tc;
  logic [2:0] b_li, b_idx;
  logic [3:0] b_q;
  seq_table_counter #(.SATURATE(1)) u_b (
    .clk(clk), .clear(b_clr), .en(b_en),
`ifdef SEQ_CNT_DOWN_EN
    .dir(b_dir),
`endif
    .load(b_ld), .load_idx(b_li), .wr_en(1'b0), .wr_addr(3'd0), .wr_data(4'd0),
    .q(b_q), .idx(b_idx), .tc(b_tc));

  // Instance C: DEPTH=16 truncation
  logic c_clr, c_en, c_dir, c_tc;
  logic [3:0] c_idx, c_q;
  seq_table_counter #(.DEPTH(16)) u_c (
    .clk(clk), .clear(c_clr), .en(c_en),
`ifdef SEQ_CNT_DOWN_EN
    .dir(c_dir),
`endif
    .load(1'b0), .load_idx(4'd0), .wr_en(1'b0), .wr_addr(4'd0), .wr_data(4'd0),
    .q(c_q), .idx(c_idx), .tc(c_tc));

  typedef struct {
    logic clr, en, ld; logic [2:0] li;
    logic we; logic [2:0] wa; logic [3:0] wd;
    logic [3:0] q; logic [2:0] idx; logic tc;
  } vec_t;

  function automatic vec_t mk(input logic clr, en, ld, input int li,
                              input logic we, input int wa, wd, q, idx, input logic tc);
    vec_t v;
    v.clr = clr; v.en = en; v.ld = ld; v.li = 3'(li);
    v.we = we; v.wa = 3'(wa); v.wd = 4'(wd);
    v.q = 4'(q); v.idx = 3'(idx); v.tc = tc;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  vec_t va[$];
  int ec [16] = '{1, 2, 3, 5, 7, 11, 13, 1, 3, 7, 13, 15, 5, 9, 11, 15};

  initial begin
    {a_clr, a_en, a_ld, a_we, b_clr, b_en, b_ld, c_clr, c_en} = '0;
    {a_dir, b_dir, c_dir} = 3'b111;
    a_li = '0; a_wa = '0; a_wd = '0; b_li = '0;

    //         clr en ld li we wa wd   q idx tc
    va.push_back(mk(1, 0, 0, 0, 0, 0, 0,  1, 0, 0));
    va.push_back(mk(0, 1, 0, 0, 0, 0, 0,  2, 1, 0));
    va.push_back(mk(0, 1, 0, 0, 0, 0, 0,  3, 2, 0));
    va.push_back(mk(0, 1, 0, 0, 0, 0, 0,  5, 3, 0));
    va.push_back(mk(0, 1, 0, 0, 0, 0, 0,  7, 4, 0));
    va.push_back(mk(0, 1, 0, 0, 0, 0, 0, 11, 5, 0));
    va.push_back(mk(0, 1, 0, 0, 0, 0, 0, 13, 6, 0));
    va.push_back(mk(0, 1, 0, 0, 0, 0, 0,  1, 0, 1));
    va.push_back(mk(0, 1, 0, 0, 0, 0, 0,  2, 1, 0));
    va.push_back(mk(0, 1, 0, 0, 1, 2, 9,  9, 2, 0));  // forwarded write
    va.push_back(mk(0, 1, 0, 0, 0, 0, 0,  5, 3, 0));
    va.push_back(mk(0, 1, 0, 0, 0, 0, 0,  7, 4, 0));
    va.push_back(mk(0, 1, 0, 0, 0, 0, 0, 11, 5, 0));
    va.push_back(mk(0, 1, 0, 0, 0, 0, 0, 13, 6, 0));
    va.push_back(mk(0, 1, 0, 0, 0, 0, 0,  1, 0, 1));
    va.push_back(mk(0, 1, 0, 0, 0, 0, 0,  2, 1, 0));
    va.push_back(mk(0, 1, 0, 0, 0, 0, 0,  9, 2, 0));  // written entry persists
    va.push_back(mk(0, 1, 1, 3, 0, 0, 0,  5, 3, 0));  // load beats en
    va.push_back(mk(0, 0, 1, 7, 0, 0, 0, 13, 6, 0));  // clamp
    va.push_back(mk(0, 1, 0, 0, 0, 0, 0,  1, 0, 1));
    va.push_back(mk(0, 0, 0, 0, 1, 0, 4,  4, 0, 0));  // write current idx
    va.push_back(mk(0, 0, 1, 7, 1, 7, 0, 13, 6, 0));  // out-of-range write dropped
    va.push_back(mk(0, 0, 1, 0, 0, 0, 0,  4, 0, 0));
    va.push_back(mk(1, 0, 0, 0, 0, 0, 0,  1, 0, 0));
    va.push_back(mk(0, 0, 1, 2, 0, 0, 0,  3, 2, 0));  // entry 2 restored
    va.push_back(mk(1, 1, 0, 0, 1, 3, 0,  1, 0, 0));  // clear discards write+step
    va.push_back(mk(0, 0, 1, 3, 0, 0, 0,  5, 3, 0));
    va.push_back(mk(0, 0, 0, 0, 0, 0, 0,  5, 3, 0));

    #2;
    foreach (va[i]) begin
      a_clr = va[i].clr; a_en = va[i].en; a_ld = va[i].ld; a_li = va[i].li;
      a_we = va[i].we; a_wa = va[i].wa; a_wd = va[i].wd;
      tick();
      chk($sformatf("a_q[%0d]", i),   a_q,   va[i].q);
      chk($sformatf("a_idx[%0d]", i), a_idx, va[i].idx);
      chk($sformatf("a_tc[%0d]", i),  a_tc,  va[i].tc);
    end
    {a_clr, a_en, a_ld, a_we} = '0;

`ifdef SEQ_CNT_DOWN_EN
    a_ld = 1; a_li = 3'd1; tick(); a_ld = 0;
    chk("dn_load_q", a_q, 2);
    a_dir = 0; a_en = 1;
    tick(); chk("dn_q0", a_q, 1);  chk("dn_tc0", a_tc, 0);
    tick(); chk("dn_q1", a_q, 13); chk("dn_tc1", a_tc, 1); chk("dn_idx1", a_idx, 6);
    tick(); chk("dn_q2", a_q, 11); chk("dn_tc2", a_tc, 0);
    a_en = 0; a_dir = 1;
`endif

    // Saturate: from idx 5 hold en for 4 cycles
    b_clr = 1; tick(); b_clr = 0;
    chk("b_rst_q", b_q, 1); chk("b_rst_tc", b_tc, 0);
    b_ld = 1; b_li = 3'd5; tick(); b_ld = 0;
    chk("b_load_q", b_q, 11);
    b_en = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("b_sat_q[%0d]", k),  b_q,  13);
      chk($sformatf("b_sat_idx[%0d]", k), b_idx, 6);
      chk($sformatf("b_sat_tc[%0d]", k), b_tc, (k == 0) ? 0 : 1);
    end
    b_en = 0; tick();
    chk("b_tc_drop", b_tc, 0);
`ifdef SEQ_CNT_DOWN_EN
    b_ld = 1; b_li = 3'd0; tick(); b_ld = 0;
    b_dir = 0; b_en = 1; tick();
    chk("b_dn_q", b_q, 1); chk("b_dn_idx", b_idx, 0); chk("b_dn_tc", b_tc, 1);
    b_en = 0; b_dir = 1;
`endif

    // DEPTH=16 walk, truncated entries
    c_clr = 1; tick(); c_clr = 0;
    chk("c_rst_q", c_q, 1); chk("c_rst_idx", c_idx, 0);
    c_en = 1;
    for (int k = 1; k < 16; k++) begin
      tick();
      chk($sformatf("c_q[%0d]", k),   c_q,   ec[k]);
      chk($sformatf("c_idx[%0d]", k), c_idx, k);
      chk($sformatf("c_tc[%0d]", k),  c_tc,  0);
    end
    tick(); chk("c_wrap_q", c_q, 1); chk("c_wrap_tc", c_tc, 1);
    tick(); chk("c_step_q", c_q, 2);
    c_clr = 1; tick(); c_clr = 0; c_en = 0;
    chk("c_clr_q", c_q, 1); chk("c_clr_idx", c_idx, 0); chk("c_clr_tc", c_tc, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/seq_table_counter.md
# seq_table_counter

Parametrised synchronous sequence counter that steps through a programmable table of DEPTH values, each WIDTH bits wide. After clear, the table holds the default non-linear sequence 1, 2, 3, 5, 7, 11, 13, 17, … truncated to DEPTH entries. It adds enable, index load, run-time table rewrite, wrap or saturate end behaviour, a terminal-count pulse and an optional down direction. It serves as the general-purpose replacement for the fixed-sequence T-flop counters in the design.

## Interface
Parameters:
- WIDTH, 4, bit width of each table entry and of q
- DEPTH, 7, number of table entries; legal range 2..16
- IDXW, $clog2(DEPTH), index width (derived; do not override)
- SATURATE, 0, end behaviour: 0 = wrap at the ends, 1 = hold at the ends

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  rising-edge clock
- clear  input  1  synchronous active-high reset; restores idx, q, tc and the full table
- en  input  1  advance one step this cycle
- dir  input  1  1 = up, 0 = down; present only with SEQ_CNT_DOWN_EN
- load  input  1  load the index from load_idx
- load_idx  input  IDXW  index to load
- wr_en  input  1  table write strobe
- wr_addr  input  IDXW  table write address
- wr_data  input  WIDTH  table write data
- q  output  WIDTH  registered value, table[idx]
- idx  output  IDXW  registered current index
- tc  output  1  registered terminal-count pulse

## Operation
- Default table, entry i for i = 0..15: 1, 2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47.
  - Entries 0..DEPTH-1 are used.
  - Each entry is truncated to its low WIDTH bits.
- Next-index selection per cycle, in priority order:
  1. clear: idx=0, q=default[0] truncated, tc=0, and all entries return to their defaults.
  2. load: idx = min(load_idx, DEPTH-1), tc=0. en is ignored.
  3. en, up direction:
     - idx < DEPTH-1: idx+1.
     - idx = DEPTH-1 and SATURATE=0: idx wraps to 0.
     - idx = DEPTH-1 and SATURATE=1: idx holds.
  4. en, down direction:
     - idx > 0: idx-1.
     - idx = 0 and SATURATE=0: idx wraps to DEPTH-1.
     - idx = 0 and SATURATE=1: idx holds.
  5. Otherwise idx holds and tc=0.
- tc=1 for one cycle after any en step taken at an end index, whether it wraps or saturates.
  - In saturate mode, tc stays high for as long as en stays asserted at the end.
- q is always loaded with the table value at the next index.
  - If wr_en is set and wr_addr equals the next index in the same cycle, q takes wr_data (write forwarding).
- Table write: when wr_en is set and clear is low, entry wr_addr = wr_data at the clock edge.
  - wr_addr ≥ DEPTH: the write is dropped.
  - A write to the current idx with no index change still updates q next cycle, via forwarding.
- clear mid-operation (including during a write) discards the write and the step.

## Timing
- Every output is registered. Latency from en, load or wr_en to q, idx or tc is exactly 1 cycle.
- Values after clear: idx=0, q=1 (WIDTH ≥ 1), tc=0.
- No combinational path from any input to any output.
- Back-to-back steps are sustained: one table entry per cycle while en=1.
- The table is a flop array. Its reads are combinational on the next index and sit inside the single register stage.

## Configuration
- SEQ_CNT_DOWN_EN defined:
  - The dir port exists.
  - dir=0 selects down stepping, with wrap or saturate at index 0 as described in Operation.
- SEQ_CNT_DOWN_EN undefined:
  - The dir port is absent.
  - The counter is up-only, and all down-direction logic is removed.

## Test plan
- Defaults (DEPTH=7, WIDTH=4): clear for 1 cycle, then en=1 for 8 cycles.
  - Required: q = 1, 2, 3, 5, 7, 11, 13, 1.
  - Required: tc=1 only in the cycle where q returns to 1.
- Saturate (SATURATE=1): from idx=5, hold en=1 for 4 cycles.
  - Required: q = 13, 13, 13, 13.
  - Required: tc=0, then 1, 1, 1 while en stays high.
- Load and priority:
  - load=1, load_idx=3, en=1 in the same cycle: required idx=3, q=5, tc=0.
  - load_idx=7 (DEPTH=7): required clamp to idx=6, q=13.
- Table write with forwarding:
  - At idx=1, assert en and wr_en with wr_addr=2, wr_data=9: required q=9 next cycle.
  - After a wrap back to idx=2: required q=9.
  - clear: required entry 2 back to 3.
- Down direction (SEQ_CNT_DOWN_EN, SATURATE=0): from idx=1, dir=0, en=1 for 3 cycles.
  - Required: q = 1, 13, 11.
  - Required: tc=1 on the cycle q becomes 13.
- Truncation and clear mid-run:
  - DEPTH=16, WIDTH=4: step through all entries; required entry 7 reads 1 (17 mod 16) and entry 15 reads 15.
  - Assert clear while en=1: required q=1, idx=0 on the next cycle.
